// File: rtl/lot_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : lot_if                                                    |
// | Brief    : Sensor, occupancy and gate/count signals of the lot.      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
interface lot_if;
  logic       car_at_entry;
  logic       car_at_exit;
  logic       hour_tick;
  logic [1:0] currCar;
  logic       entry_open;
  logic       exit_open;
  logic       entrance_gate;
  logic       exit_gate;
  logic [2:0] hour;
  logic       full;
  logic       day_done;

  modport master (
    output car_at_entry, car_at_exit, hour_tick, currCar,
    input  entry_open, exit_open, entrance_gate, exit_gate, hour, full, day_done
  );

  modport slave (
    input  car_at_entry, car_at_exit, hour_tick, currCar,
    output entry_open, exit_open, entrance_gate, exit_gate, hour, full, day_done
  );
endinterface
`default_nettype wire

// File: rtl/lot_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : lot_controller                                            |
// | Brief    : Entry/exit gate sequencer with hour clock and day end.    |
// |            Macro LOT_EXIT_PRIORITY_EN: ties always go to the exit.   |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module lot_controller #(
  parameter int GATE_TIMEOUT = 8
) (
  input  logic clk,
  input  logic reset,
  lot_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ENTRY_OPEN = 3'd1,
    ENTRY_PASS = 3'd2,
    EXIT_OPEN  = 3'd3,
    EXIT_PASS  = 3'd4,
    DAY_END    = 3'd5
  } state_t;

  localparam logic [3:0] c_timeout   = 4'(GATE_TIMEOUT);
  localparam logic [2:0] c_last_hour = 3'd7;

  state_t     r_state, w_state_nx;
  logic [3:0] r_timer, w_timer_nx;
  logic [2:0] r_hour;
  logic       r_day_done;
  logic       r_entrance_gate, w_entrance_nx;
  logic       r_exit_gate, w_exit_nx;
  logic       w_entry_req, w_exit_req, w_end_day, w_tie_to_entry;

  assign bus.full      = (bus.currCar == 2'd3);
  assign w_entry_req   = bus.car_at_entry && (bus.currCar != 2'd3);
  assign w_exit_req    = bus.car_at_exit && (bus.currCar != 2'd0);
  // The last-hour tick counts as day end in the same cycle it arrives
  assign w_end_day     = r_day_done || (bus.hour_tick && (r_hour == c_last_hour));

  assign bus.entry_open    = (r_state == ENTRY_OPEN) || (r_state == ENTRY_PASS);
  assign bus.exit_open     = (r_state == EXIT_OPEN)  || (r_state == EXIT_PASS);
  assign bus.entrance_gate = r_entrance_gate;
  assign bus.exit_gate     = r_exit_gate;
  assign bus.hour          = r_hour;
  assign bus.day_done      = r_day_done;

`ifdef LOT_EXIT_PRIORITY_EN
  assign w_tie_to_entry = 1'b0;
`else
  localparam logic c_grant_exit = 1'b1;
  logic r_last_grant;
  logic w_tie;

  assign w_tie = (r_state == IDLE) && !w_end_day && w_entry_req && w_exit_req;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_last_grant <= c_grant_exit;
    end else if (w_tie) begin
      r_last_grant <= ~r_last_grant;
    end
  end

  assign w_tie_to_entry = (r_last_grant == c_grant_exit);
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state         <= IDLE;
      r_timer         <= 4'd0;
      r_hour          <= 3'd0;
      r_day_done      <= 1'b0;
      r_entrance_gate <= 1'b0;
      r_exit_gate     <= 1'b0;
    end else begin
      r_state         <= w_state_nx;
      r_timer         <= w_timer_nx;
      r_entrance_gate <= w_entrance_nx;
      r_exit_gate     <= w_exit_nx;
      if (bus.hour_tick && (r_state != DAY_END)) begin
        if (r_hour == c_last_hour) begin
          r_day_done <= 1'b1;
        end else begin
          r_hour <= r_hour + 3'd1;
        end
      end
    end
  end

  always_comb begin
    w_state_nx    = r_state;
    w_timer_nx    = r_timer;
    w_entrance_nx = 1'b0;
    w_exit_nx     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_end_day) begin
          w_state_nx = DAY_END;
        end else if (w_entry_req && (!w_exit_req || w_tie_to_entry)) begin
          w_state_nx = ENTRY_OPEN;
          w_timer_nx = c_timeout;
        end else if (w_exit_req) begin
          w_state_nx = EXIT_OPEN;
          w_timer_nx = c_timeout;
        end
      end
      ENTRY_OPEN: begin
        w_timer_nx = r_timer - 4'd1;
        if (r_timer <= 4'd1) begin
          w_state_nx = IDLE;
          w_timer_nx = 4'd0;
        end else if (bus.car_at_entry) begin
          w_state_nx = ENTRY_PASS;
        end
      end
      ENTRY_PASS: begin
        w_timer_nx = r_timer - 4'd1;
        // A car clearing the lane on the last cycle still counts
        if (!bus.car_at_entry) begin
          w_state_nx    = IDLE;
          w_timer_nx    = 4'd0;
          w_entrance_nx = 1'b1;
        end else if (r_timer <= 4'd1) begin
          w_state_nx = IDLE;
          w_timer_nx = 4'd0;
        end
      end
      EXIT_OPEN: begin
        w_timer_nx = r_timer - 4'd1;
        if (r_timer <= 4'd1) begin
          w_state_nx = IDLE;
          w_timer_nx = 4'd0;
        end else if (bus.car_at_exit) begin
          w_state_nx = EXIT_PASS;
        end
      end
      EXIT_PASS: begin
        w_timer_nx = r_timer - 4'd1;
        if (!bus.car_at_exit) begin
          w_state_nx = IDLE;
          w_timer_nx = 4'd0;
          w_exit_nx  = 1'b1;
        end else if (r_timer <= 4'd1) begin
          w_state_nx = IDLE;
          w_timer_nx = 4'd0;
        end
      end
      DAY_END: begin
        w_state_nx = DAY_END;
      end
      default: begin
        w_state_nx = IDLE;
        w_timer_nx = 4'd0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_lot_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_lot_controller                                         |
// | Brief    : Directed self-checking bench for lot_controller.          |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_lot_controller;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_open;
  int   n_pulse;

  lot_if bus ();

  lot_controller #(.GATE_TIMEOUT(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
  endtask

  task automatic pulse_hour();
    bus.hour_tick = 1'b1;
    tick(1);
    bus.hour_tick = 1'b0;
  endtask

  task automatic tie_round(input string tag, input logic exp_entry);
    bus.car_at_entry = 1'b1;
    bus.car_at_exit  = 1'b1;
    tick(1);
    chk({tag, "_entry_open"}, 8'(bus.entry_open), 8'(exp_entry));
    chk({tag, "_exit_open"},  8'(bus.exit_open),  8'(!exp_entry));
    tick(1);
    bus.car_at_entry = 1'b0;
    bus.car_at_exit  = 1'b0;
    tick(1);
    chk({tag, "_entrance_gate"}, 8'(bus.entrance_gate), 8'(exp_entry));
    chk({tag, "_exit_gate"},     8'(bus.exit_gate),     8'(!exp_entry));
    tick(1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset            = 1'b0;
    bus.car_at_entry = 1'b0;
    bus.car_at_exit  = 1'b0;
    bus.hour_tick    = 1'b0;
    bus.currCar      = 2'd0;
    tick(2);
    chk("rst_entry_open",    8'(bus.entry_open),    8'h0);
    chk("rst_exit_open",     8'(bus.exit_open),     8'h0);
    chk("rst_entrance_gate", 8'(bus.entrance_gate), 8'h0);
    chk("rst_exit_gate",     8'(bus.exit_gate),     8'h0);
    chk("rst_hour",          8'(bus.hour),          8'h0);
    chk("rst_day_done",      8'(bus.day_done),      8'h0);
    chk("rst_full",          8'(bus.full),          8'h0);
    reset = 1'b1;

    // Basic entry: sensor high two cycles, pulse three cycles after request
    bus.car_at_entry = 1'b1;
    tick(1);
    chk("ent_open_c1",  8'(bus.entry_open),    8'h1);
    chk("ent_pulse_c1", 8'(bus.entrance_gate), 8'h0);
    tick(1);
    chk("ent_open_c2",  8'(bus.entry_open),    8'h1);
    bus.car_at_entry = 1'b0;
    tick(1);
    chk("ent_open_c3",  8'(bus.entry_open),    8'h0);
    chk("ent_pulse_c3", 8'(bus.entrance_gate), 8'h1);
    tick(1);
    chk("ent_pulse_c4", 8'(bus.entrance_gate), 8'h0);

    // Lot full: entry refused
    bus.currCar = 2'd3;
    tick(1);
    chk("full_flag", 8'(bus.full), 8'h1);
    bus.car_at_entry = 1'b1;
    n_open  = 0;
    n_pulse = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (bus.entry_open)    n_open++;
      if (bus.entrance_gate) n_pulse++;
    end
    chk("full_no_open",  8'(n_open),  8'h0);
    chk("full_no_pulse", 8'(n_pulse), 8'h0);
    bus.car_at_entry = 1'b0;

    // Empty lot: exit refused
    bus.currCar     = 2'd0;
    bus.car_at_exit = 1'b1;
    tick(3);
    chk("empty_no_exit", 8'(bus.exit_open), 8'h0);
    bus.car_at_exit = 1'b0;

    // Exit timeout with the sensor stuck high
    bus.currCar     = 2'd2;
    bus.car_at_exit = 1'b1;
    n_open  = 0;
    n_pulse = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (bus.exit_open) n_open++;
      if (bus.exit_gate) n_pulse++;
      if (i > 0 && !bus.exit_open) break;
    end
    bus.car_at_exit = 1'b0;
    chk("tmo_open_cycles", 8'(n_open),  8'h8);
    chk("tmo_no_pulse",    8'(n_pulse), 8'h0);
    tick(1);
    chk("tmo_idle_closed", 8'(bus.exit_open), 8'h0);
    chk("tmo_idle_pulse",  8'(bus.exit_gate), 8'h0);

    // Simultaneous requests
    do_reset();
    bus.currCar = 2'd1;
`ifdef LOT_EXIT_PRIORITY_EN
    tie_round("tie1", 1'b0);
    tie_round("tie2", 1'b0);
`else
    tie_round("tie1", 1'b1);
    tie_round("tie2", 1'b0);
`endif

    // Reset in the middle of an exit
    pulse_hour();
    pulse_hour();
    pulse_hour();
    chk("hour_three", 8'(bus.hour), 8'h3);
    bus.currCar     = 2'd2;
    bus.car_at_exit = 1'b1;
    tick(2);
    chk("mid_exit_open", 8'(bus.exit_open), 8'h1);
    reset = 1'b0;
    tick(1);
    chk("mid_rst_exit_open", 8'(bus.exit_open), 8'h0);
    chk("mid_rst_hour",      8'(bus.hour),      8'h0);
    chk("mid_rst_exit_gate", 8'(bus.exit_gate), 8'h0);
    reset           = 1'b1;
    bus.car_at_exit = 1'b0;
    tick(1);
    chk("post_rst_exit_gate", 8'(bus.exit_gate), 8'h0);

    // End of day arriving mid-entry
    for (int i = 0; i < 7; i++) pulse_hour();
    chk("day_hour7",    8'(bus.hour),     8'h7);
    chk("day_not_done", 8'(bus.day_done), 8'h0);
    bus.currCar      = 2'd1;
    bus.car_at_entry = 1'b1;
    tick(2);
    chk("day_in_pass", 8'(bus.entry_open), 8'h1);
    pulse_hour();
    chk("day_done_set",  8'(bus.day_done),   8'h1);
    chk("day_hour_hold", 8'(bus.hour),       8'h7);
    chk("day_gate_held", 8'(bus.entry_open), 8'h1);
    bus.car_at_entry = 1'b0;
    tick(1);
    chk("day_final_pulse", 8'(bus.entrance_gate), 8'h1);
    chk("day_final_close", 8'(bus.entry_open),    8'h0);
    tick(1);
    bus.car_at_entry = 1'b1;
    bus.car_at_exit  = 1'b1;
    bus.hour_tick    = 1'b1;
    n_open  = 0;
    n_pulse = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (bus.entry_open || bus.exit_open)    n_open++;
      if (bus.entrance_gate || bus.exit_gate) n_pulse++;
    end
    bus.hour_tick = 1'b0;
    chk("dayend_no_open",  8'(n_open),       8'h0);
    chk("dayend_no_pulse", 8'(n_pulse),      8'h0);
    chk("dayend_hour",     8'(bus.hour),     8'h7);
    chk("dayend_sticky",   8'(bus.day_done), 8'h1);
    bus.car_at_entry = 1'b0;
    bus.car_at_exit  = 1'b0;
    reset = 1'b0;
    tick(1);
    chk("dayend_rst_done", 8'(bus.day_done), 8'h0);
    reset = 1'b1;
    tick(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lot_controller.md
LOT_CONTROLLER -- requirements
Module: lot_controller

Interface
REQ-001 SHALL have parameter GATE_TIMEOUT, default 8: maximum cycles a gate stays open awaiting car passage (range 2..15).
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1: reset is synchronous and active-low.
REQ-004 SHALL have port car_at_entry, input, 1: entry sensor level; high while a car waits at or occupies the entry lane.
REQ-005 SHALL have port car_at_exit, input, 1: exit sensor level; high while a car waits at or occupies the exit lane.
REQ-006 SHALL have port hour_tick, input, 1: one-cycle pulse that advances the simulated hour.
REQ-007 SHALL have port currCar, input, 2: lot occupancy fed back from the datapath (0..3).
REQ-008 SHALL have port entry_open, output, 1: entry gate actuator; high while the entry gate is open.
REQ-009 SHALL have port exit_open, output, 1: exit gate actuator; high while the exit gate is open.
REQ-010 SHALL have port entrance_gate, output, 1: one-cycle count pulse to the datapath on a completed entry.
REQ-011 SHALL have port exit_gate, output, 1: one-cycle count pulse to the datapath on a completed exit.
REQ-012 SHALL have port hour, output, 3: current hour 0..7.
REQ-013 SHALL have port full, output, 1: combinational, high when currCar == 3.
REQ-014 SHALL have port day_done, output, 1: high once the day has ended; sticky until reset.

Function
REQ-015 SHALL implement FSM states IDLE, ENTRY_OPEN, ENTRY_PASS, EXIT_OPEN, EXIT_PASS, DAY_END.
REQ-016 SHALL, in IDLE, treat the entry request as valid only when car_at_entry && !full; the exit request as valid only when car_at_exit && currCar != 0.
REQ-017 SHALL, in IDLE with one valid request, go to the matching *_OPEN state on the next edge.
REQ-018 SHALL, in IDLE with both requests valid, grant by round-robin: grant the side opposite last_grant, then update last_grant; last_grant resets to exit, so the first tie goes to entry.
REQ-019 SHALL assert entry_open in ENTRY_OPEN and ENTRY_PASS, and exit_open in EXIT_OPEN and EXIT_PASS; both are low in all other states and never high together.
REQ-020 SHALL, in *_OPEN, load the timeout counter with GATE_TIMEOUT on entry, decrement it each cycle, and move to *_PASS once the sensor is seen high.
REQ-021 SHALL, in *_PASS, detect sensor deassertion, pulse entrance_gate (or exit_gate) for exactly one cycle in the cycle the FSM returns to IDLE, and close the gate in that same cycle.
REQ-022 SHALL, if the timeout counter reaches 0 in *_OPEN or *_PASS, return to IDLE with no count pulse.
REQ-023 SHALL give each transaction a minimum latency of 3 cycles from the request being sampled in IDLE to the count pulse (IDLE, OPEN, PASS, then pulse).
REQ-024 SHALL increment hour on each hour_tick in any state except DAY_END.
REQ-025 SHALL, on hour_tick while hour == 7, hold hour at 7, set day_done, and enter DAY_END from IDLE, or after the in-flight transaction completes or times out.
REQ-026 SHALL, in DAY_END, keep both gates closed, emit no count pulses, ignore the sensors and hour_tick, and remain there until reset.
REQ-027 SHALL re-evaluate requests only in IDLE; a sensor change mid-transaction does not preempt it.

Reset
REQ-028 SHALL, with reset low at a rising edge, set state=IDLE, hour=0, day_done=0, last_grant=exit, timeout counter=0, entry_open=exit_open=entrance_gate=exit_gate=0.
REQ-029 SHALL, on reset asserted mid-transaction, close the open gate on the next edge with no count pulse.

Configuration
REQ-030 SHALL support macro LOT_EXIT_PRIORITY_EN: when defined, a tie in IDLE always grants exit and last_grant is unused; when undefined, round-robin per REQ-018 applies.

Verification
REQ-031 SHALL cover: currCar=0, car_at_entry high 2 cycles then low -> entry_open high 2 cycles, entrance_gate single pulse 3 cycles after request.
REQ-032 SHALL cover: currCar=3, car_at_entry held high 10 cycles -> full=1, entry_open stays 0, no entrance_gate pulse.
REQ-033 SHALL cover: currCar=1, both sensors raised together, repeated twice -> grants entry then exit (macro undefined); exit both times (macro defined).
REQ-034 SHALL cover: GATE_TIMEOUT=8, car_at_exit held high indefinitely -> exit_open deasserts after 8 cycles, no exit_gate pulse, FSM returns to IDLE.
REQ-035 SHALL cover: 8 hour_tick pulses, the 8th during ENTRY_PASS -> hour=7, day_done=1, entry pulse completes, then DAY_END with gates locked.
REQ-036 SHALL cover: reset low during EXIT_PASS -> exit_open=0 and hour=0 next cycle, no exit_gate pulse.
